// File: rtl/switch_debounce_pkg.sv
// -----------------------------------------------------------------------------
// switch_debounce_pkg
//   Shared definitions for the switch debouncer:
//     - debounce_state_e : qualification state machine encoding
//     - DEBOUNCE_LIMIT_DEFAULT   : 10 ms at 25 MHz
//     - LONG_PRESS_LIMIT_DEFAULT : 1 s at 25 MHz (long-press build only)
// -----------------------------------------------------------------------------
package switch_debounce_pkg;

    typedef enum logic [1:0] {
        ST_LOW      = 2'd0,  // stable level is 0
        ST_CHK_HIGH = 2'd1,  // synchronized 1 being qualified
        ST_HIGH     = 2'd2,  // stable level is 1
        ST_CHK_LOW  = 2'd3   // synchronized 0 being qualified
    } debounce_state_e;

    localparam int DEBOUNCE_LIMIT_DEFAULT   = 250000;
    localparam int LONG_PRESS_LIMIT_DEFAULT = 25000000;

endpackage : switch_debounce_pkg

// File: rtl/switch_sync.sv
// -----------------------------------------------------------------------------
// switch_sync
//   Parameterised flop-chain synchroniser for a single asynchronous pin.
//   Parameters:
//     STAGES : number of flops in the chain (>= 2)
//   Ports:
//     clk   : destination clock
//     rst_n : asynchronous active-low reset, clears every stage
//     d     : asynchronous input
//     q     : synchronized output (last stage)
// -----------------------------------------------------------------------------
module switch_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // NOTE: sequential state is always written with non-blocking assignments so
    // every flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule : switch_sync

// File: rtl/switch_debounce_events.sv
// -----------------------------------------------------------------------------
// switch_debounce_events
//   Turns a raw bouncing switch pin into a clean debounced level and
//   single-cycle press / release event pulses, all in the i_Clk domain.
//   Optional feature macro: DEBOUNCE_LONG_PRESS_EN adds the o_Long_Press pulse,
//   the hold counter and the LONG_PRESS_LIMIT parameter.
//   Parameters:
//     DEBOUNCE_LIMIT   : cycles a new level must persist before acceptance (>= 2)
//     SYNC_STAGES      : synchroniser depth (>= 2)
//     LONG_PRESS_LIMIT : hold cycles before o_Long_Press (macro builds only)
//   Ports:
//     i_Clk        : clock
//     i_Rst_L      : asynchronous active-low reset
//     i_Switch     : raw switch pin, asynchronous to i_Clk
//     o_Switch     : debounced level
//     o_Press      : one-cycle pulse on accepted 0->1
//     o_Release    : one-cycle pulse on accepted 1->0
//     o_Long_Press : one-cycle pulse after LONG_PRESS_LIMIT cycles held
//                    (macro builds only)
//   All outputs are registered.
// -----------------------------------------------------------------------------
module switch_debounce_events
    import switch_debounce_pkg::*;
#(
    parameter int DEBOUNCE_LIMIT = DEBOUNCE_LIMIT_DEFAULT,
    parameter int SYNC_STAGES    = 2
`ifdef DEBOUNCE_LONG_PRESS_EN
   ,parameter int LONG_PRESS_LIMIT = LONG_PRESS_LIMIT_DEFAULT
`endif
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Press,
    output logic o_Release
`ifdef DEBOUNCE_LONG_PRESS_EN
   ,output logic o_Long_Press
`endif
);

    // The counter only ever holds 0 .. DEBOUNCE_LIMIT-1, so this width is exact.
    localparam int                CNT_W   = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic            sync_level;
    debounce_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            press_q, press_d;
    logic            release_q, release_d;

    switch_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (i_Clk),
        .rst_n (i_Rst_L),
        .d     (i_Switch),
        .q     (sync_level)
    );

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= ST_LOW;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;

        unique case (state_q)
            ST_LOW: begin
                if (sync_level) begin
                    state_d = ST_CHK_HIGH;
                    cnt_d   = CNT_ONE;  // this cycle already counts as the first
                end
            end
            ST_CHK_HIGH: begin
                if (!sync_level) begin
                    state_d = ST_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!sync_level) begin
                    state_d = ST_CHK_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_CHK_LOW: begin
                if (sync_level) begin
                    state_d = ST_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = ST_LOW;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign o_Switch  = level_q;
    assign o_Press   = press_q;
    assign o_Release = release_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
    localparam int               LP_W     = $clog2(LONG_PRESS_LIMIT + 1);
    localparam logic [LP_W-1:0]  LP_MAX   = LP_W'(LONG_PRESS_LIMIT);
    localparam logic [LP_W-1:0]  LP_ONE   = LP_W'(1);

    logic [LP_W-1:0] long_cnt_q;
    logic            long_pulse_q;
    logic            held;

    // ST_CHK_LOW still counts as held: a bounce back to ST_HIGH must not
    // restart the long-press timer.
    assign held = (state_q == ST_HIGH) || (state_q == ST_CHK_LOW);

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            long_cnt_q   <= '0;
            long_pulse_q <= 1'b0;
        end else if (release_d) begin
            long_cnt_q   <= '0;
            long_pulse_q <= 1'b0;
        end else if (held && (long_cnt_q != LP_MAX)) begin
            // Saturates at LP_MAX, so the pulse fires only once per hold.
            long_cnt_q   <= long_cnt_q + LP_ONE;
            long_pulse_q <= (long_cnt_q == LP_MAX - LP_ONE);
        end else begin
            long_pulse_q <= 1'b0;
        end
    end

    assign o_Long_Press = long_pulse_q;
`endif

endmodule : switch_debounce_events

// File: tb/tb_switch_debounce_events.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce_events
//   Scoreboard bench: each stimulus pushes the event it should cause, with the
//   clock edge it must land on; a negedge monitor pops and compares every
//   pulse the DUT produces. Build with DEBOUNCE_LONG_PRESS_EN to cover the
//   long-press feature as well.
// -----------------------------------------------------------------------------
module tb_switch_debounce_events;
    import switch_debounce_pkg::*;

    localparam int DEB  = 4;
    localparam int SYNC = 2;
    localparam int LONG = 10;
    localparam int LAT  = SYNC + DEB;  // edges from first sample to event

    typedef enum int {EV_PRESS = 0, EV_RELEASE = 1, EV_LONG = 2} ev_e;
    typedef struct {
        int  cyc;
        ev_e kind;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sw = 1'b0;
    logic level, press, release_ev;
`ifdef DEBOUNCE_LONG_PRESS_EN
    logic long_press;
`endif

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    switch_debounce_events #(
        .DEBOUNCE_LIMIT (DEB),
        .SYNC_STAGES    (SYNC)
`ifdef DEBOUNCE_LONG_PRESS_EN
       ,.LONG_PRESS_LIMIT (LONG)
`endif
    ) dut (
        .i_Clk     (clk),
        .i_Rst_L   (rst_n),
        .i_Switch  (sw),
        .o_Switch  (level),
        .o_Press   (press),
        .o_Release (release_ev)
`ifdef DEBOUNCE_LONG_PRESS_EN
       ,.o_Long_Press (long_press)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic expect_ev(input ev_e kind, input int at);
        exp_t e;
        e.cyc  = at;
        e.kind = kind;
        sb.push_back(e);
    endtask

    task automatic take(input ev_e kind);
        exp_t e;
        if (sb.size() == 0) begin
            check($sformatf("unexpected %s", kind.name()), 1, 0);
        end else begin
            e = sb.pop_front();
            check($sformatf("%s kind", kind.name()), kind, e.kind);
            check($sformatf("%s edge", kind.name()), cyc, e.cyc);
            if (kind == EV_PRESS)   check("level after press", level, 1);
            if (kind == EV_RELEASE) check("level after release", level, 0);
        end
    endtask

    // Monitor: sample outputs on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (press && release_ev) check("press/release exclusive", 1, 0);
            if (press)      take(EV_PRESS);
            if (release_ev) take(EV_RELEASE);
`ifdef DEBOUNCE_LONG_PRESS_EN
            if (long_press) take(EV_LONG);
`endif
        end
    end

    // Wait for every pushed expectation to be consumed, then linger so that
    // any extra pulse reaches the monitor as unexpected.
    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            check("drain timeout, pending", sb.size(), 0);
            sb.delete();
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic step_to(input logic v);
        @(negedge clk);
        sw = v;
    endtask

    initial begin
        logic [7:0] bounce;

        // Reset state
        #1;
        check("reset o_Switch", level, 0);
        check("reset o_Press", press, 0);
        check("reset o_Release", release_ev, 0);
`ifdef DEBOUNCE_LONG_PRESS_EN
        check("reset o_Long_Press", long_press, 0);
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press
        step_to(1'b1);
        expect_ev(EV_PRESS, cyc + LAT);
`ifdef DEBOUNCE_LONG_PRESS_EN
        expect_ev(EV_LONG, cyc + LAT + LONG);
        drain(40);
`else
        drain(20);
`endif
        check("held level", level, 1);

        // Release
        step_to(1'b0);
        expect_ev(EV_RELEASE, cyc + LAT);
        drain(20);
        check("released level", level, 0);

        // Bounce: 1,1,1,0 then 1s; qualification restarts after the 0
        bounce = 8'b1111_0111;  // bit i is driven for edge i+1
        @(negedge clk);
        expect_ev(EV_PRESS, cyc + 10);
        sw = bounce[0];
        for (int i = 1; i < 8; i++) begin
            @(negedge clk);
            sw = bounce[i];
        end
`ifdef DEBOUNCE_LONG_PRESS_EN
        expect_ev(EV_LONG, sb[0].cyc + LONG);
        drain(40);
`else
        drain(20);
`endif
        step_to(1'b0);
        expect_ev(EV_RELEASE, cyc + LAT);
        drain(20);

        // Short glitch: 3 cycles high, one short of the limit
        step_to(1'b1);
        repeat (3) @(negedge clk);
        sw = 1'b0;
        drain(1);
        repeat (4) @(negedge clk);
        check("glitch level", level, 0);
        check("glitch state", 32'(dut.state_q), 32'(ST_LOW));
        check("glitch counter", 32'(dut.cnt_q), 0);

        // Reset mid-qualification, switch held at 1 across reset
        step_to(1'b1);
        repeat (3) @(negedge clk);
        check("pre-reset state", 32'(dut.state_q), 32'(ST_CHK_HIGH));
        #2 rst_n = 1'b0;
        #1;
        check("midq reset o_Switch", level, 0);
        check("midq reset o_Press", press, 0);
        check("midq reset state", 32'(dut.state_q), 32'(ST_LOW));
        check("midq reset counter", 32'(dut.cnt_q), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_ev(EV_PRESS, cyc + LAT);
        drain(20);

        // Reset while stable high clears the level at once
        #2 rst_n = 1'b0;
        #1;
        check("high reset o_Switch", level, 0);
        check("high reset o_Release", release_ev, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        expect_ev(EV_PRESS, cyc + LAT);
`ifdef DEBOUNCE_LONG_PRESS_EN
        expect_ev(EV_LONG, cyc + LAT + LONG);
        drain(40);
        // Hold well past the limit: no second long pulse may appear.
        repeat (3 * LONG) @(negedge clk);
        // Short dip into ST_CHK_LOW and back must not cause anything.
        sw = 1'b0;
        repeat (2) @(negedge clk);
        sw = 1'b1;
        repeat (10) @(negedge clk);
        check("level after dip", level, 1);
`else
        drain(20);
`endif
        step_to(1'b0);
        expect_ev(EV_RELEASE, cyc + LAT);
        drain(20);

`ifdef DEBOUNCE_LONG_PRESS_EN
        // Long press rearms after release
        step_to(1'b1);
        expect_ev(EV_PRESS, cyc + LAT);
        expect_ev(EV_LONG, cyc + LAT + LONG);
        drain(40);
        step_to(1'b0);
        expect_ev(EV_RELEASE, cyc + LAT);
        drain(20);
`endif

        check("final level", level, 0);
        check("scoreboard empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends on its own.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_switch_debounce_events
